// File: rtl/usb_tx_pkt_ctrl.sv
// USB tx packet controller: feeds SYNC, PID and payload bytes to the serializer and enforces the
// inter-packet gap. Define USB_TXC_WDOG_EN to build in the WAIT_END watchdog.
module usb_tx_pkt_ctrl #(
  parameter int unsigned IPG_CYCLES  = 8,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_req,
  input  logic [1:0] pkt_type,
  input  logic [3:0] pkt_pid,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic       pkt_ack,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       busy,
  output logic       SYN_GEN_LD,
  output logic       TX_LOAD,
  output logic       CRC_16,
  output logic       TX_LAST_BYTE,
  output logic [7:0] tx_data,
  input  logic       TX_READY_LD,
  input  logic       T_lastbit
);

  localparam logic [1:0] TypeHs   = 2'd0;
  localparam logic [1:0] TypeTok  = 2'd1;
  localparam logic [1:0] TypeData = 2'd2;
  localparam logic [1:0] TypeRsvd = 2'd3;

`ifdef USB_TXC_WDOG_EN
  localparam int unsigned CntMax = (IPG_CYCLES > WDOG_CYCLES) ? IPG_CYCLES : WDOG_CYCLES;
`else
  localparam int unsigned CntMax = IPG_CYCLES;
  // WDOG_CYCLES only sizes the watchdog, which is not built here.
  if (WDOG_CYCLES == 0) begin : g_wdog_unused
  end
`endif
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {StIdle, StSync, StPid, StPayload, StWaitEnd, StGap} state_e;

  state_e          state_q, state_d;
  logic [1:0]      type_q, type_d;
  logic [3:0]      pid_q, pid_d;
  logic            ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic            reject_q, reject_d;
  logic            second_q, second_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_valid_q, hold_last_q, got_last_q;
  logic [7:0]      hold_data_q;
  logic            consume, pl_accept;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    pid_d    = pid_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    reject_d = reject_q && pkt_req;
    second_d = second_q;
    consume  = 1'b0;
    case (state_q)
      StIdle: begin
        // A reserved request flags once, then is ignored until the requester lets go.
        if (pkt_req && !reject_q) begin
          if (pkt_type == TypeRsvd) begin
            err_d    = 1'b1;
            reject_d = 1'b1;
          end else begin
            ack_d    = 1'b1;
            type_d   = pkt_type;
            pid_d    = pkt_pid;
            second_d = 1'b0;
            state_d  = StSync;
          end
        end
      end
      StSync: if (TX_READY_LD) state_d = StPid;
      StPid: if (TX_READY_LD) state_d = (type_q == TypeHs) ? StWaitEnd : StPayload;
      StPayload: begin
        if (TX_READY_LD) begin
          // Tokens carry exactly two bytes: last must be clear on byte 0 and set on byte 1.
          if (!hold_valid_q || (type_q == TypeTok && hold_last_q != second_q)) begin
            err_d   = 1'b1;
            state_d = StGap;
          end else begin
            consume  = 1'b1;
            second_d = 1'b1;
            if (hold_last_q) state_d = StWaitEnd;
          end
        end
      end
      StWaitEnd: begin
        if (T_lastbit) begin
          done_d  = 1'b1;
          state_d = StGap;
        end
`ifdef USB_TXC_WDOG_EN
        else if (cnt_q == CntW'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StGap;
        end
`endif
      end
      StGap: if (cnt_q == CntW'(IPG_CYCLES - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = '0;
`ifdef USB_TXC_WDOG_EN
    if (state_d == state_q && (state_q == StGap || state_q == StWaitEnd)) cnt_d = cnt_q + 1'b1;
`else
    if (state_d == state_q && state_q == StGap) cnt_d = cnt_q + 1'b1;
`endif
  end

  // Refill is allowed in the cycle the held byte is consumed, so back-to-back bytes see no bubble.
  assign pl_ready  = (state_q == StPayload || (state_q == StPid && type_q != TypeHs)) &&
                     !got_last_q && (!hold_valid_q || consume);
  assign pl_accept = pl_valid && pl_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      type_q   <= TypeHs;
      pid_q    <= 4'h0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      reject_q <= 1'b0;
      second_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      pid_q    <= pid_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      reject_q <= reject_d;
      second_q <= second_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_data_q  <= 8'h00;
      got_last_q   <= 1'b0;
    end else if (state_q == StIdle || state_q == StGap) begin
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      got_last_q   <= 1'b0;
    end else if (pl_accept) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= pl_data;
      hold_last_q  <= pl_last;
      if (pl_last) got_last_q <= 1'b1;
    end else if (consume) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_comb begin
    SYN_GEN_LD   = 1'b0;
    TX_LOAD      = 1'b0;
    TX_LAST_BYTE = 1'b0;
    tx_data      = 8'h00;
    case (state_q)
      StSync: begin
        SYN_GEN_LD = 1'b1;
        TX_LOAD    = 1'b1;
        tx_data    = 8'h80;
      end
      StPid: begin
        TX_LOAD      = 1'b1;
        TX_LAST_BYTE = (type_q == TypeHs);
        tx_data      = {~pid_q, pid_q};
      end
      StPayload: begin
        TX_LOAD      = 1'b1;
        TX_LAST_BYTE = hold_valid_q && hold_last_q;
        tx_data      = hold_data_q;
      end
      StWaitEnd: TX_LAST_BYTE = 1'b1;
      default: ;
    endcase
  end

  assign CRC_16   = (type_q == TypeData) &&
                    (state_q == StPid || state_q == StPayload || state_q == StWaitEnd);
  assign busy     = (state_q != StIdle);
  assign pkt_ack  = ack_q;
  assign pkt_done = done_q;
  assign pkt_err  = err_q;

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Self-checking bench for usb_tx_pkt_ctrl: a scoreboard of expected serializer bytes plus pulse,
// gap and reset checks.
module tb_usb_tx_pkt_ctrl;
  localparam int Ipg  = 8;
  localparam int Wdog = 256;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_req = 1'b0;
  logic [1:0] pkt_type = 2'd0;
  logic [3:0] pkt_pid = 4'h0;
  logic       pl_valid, pl_last;
  logic [7:0] pl_data;
  logic       pl_ready, pkt_ack, pkt_done, pkt_err, busy;
  logic       SYN_GEN_LD, TX_LOAD, CRC_16, TX_LAST_BYTE;
  logic [7:0] tx_data;
  logic       TX_READY_LD = 1'b0;
  logic       T_lastbit = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [8:0]  src_q[$];  // {last, data} fed on the payload port
  logic [10:0] exp_q[$];  // {SYN_GEN_LD, CRC_16, TX_LAST_BYTE, tx_data} per consumed byte
  int cyc = 0;
  int ack_cyc = 0, done_cyc = 0, n_ack = 0, n_done = 0, n_err = 0, viol = 0;
  logic fire = 1'b0;
  logic prev_ack = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  usb_tx_pkt_ctrl #(.IPG_CYCLES(Ipg), .WDOG_CYCLES(Wdog)) dut (
    .clock(clock), .reset(reset), .pkt_req(pkt_req), .pkt_type(pkt_type), .pkt_pid(pkt_pid),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last), .pl_ready(pl_ready),
    .pkt_ack(pkt_ack), .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy),
    .SYN_GEN_LD(SYN_GEN_LD), .TX_LOAD(TX_LOAD), .CRC_16(CRC_16), .TX_LAST_BYTE(TX_LAST_BYTE),
    .tx_data(tx_data), .TX_READY_LD(TX_READY_LD), .T_lastbit(T_lastbit)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    fire = pl_valid && pl_ready;
    if (pkt_ack) begin n_ack++; ack_cyc = cyc; end
    if (pkt_done) begin n_done++; done_cyc = cyc; end
    if (pkt_err) n_err++;
    if (int'(pkt_ack) + int'(pkt_done) + int'(pkt_err) > 1) viol++;
    if ((pkt_ack && prev_ack) || (pkt_done && prev_done) || (pkt_err && prev_err)) viol++;
    prev_ack = pkt_ack; prev_done = pkt_done; prev_err = pkt_err;
  end

  // Payload source: presents the head of src_q, pops it once accepted.
  initial begin
    pl_valid = 1'b0; pl_data = 8'h00; pl_last = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        {pl_last, pl_data} = src_q[0];
        pl_valid = 1'b1;
      end else pl_valid = 1'b0;
    end
  end

  task automatic do_req(input logic [1:0] t, input logic [3:0] p, output int lat);
    int n = 0;
    @(posedge clock); #1;
    pkt_req = 1'b1; pkt_type = t; pkt_pid = p;
    lat = -1;
    while (n < 40) begin
      @(posedge clock); @(negedge clock); n++;
      if (pkt_ack || pkt_err) begin lat = n; break; end
    end
    @(posedge clock); #1;
    pkt_req = 1'b0;
  endtask

  // Serializer model: consumes one byte 8 clocks after TX_LOAD is seen.
  task automatic ser_byte(output logic [10:0] obs, output bit ok);
    int n = 0;
    ok = 1'b1; obs = '0;
    while (TX_LOAD !== 1'b1) begin
      @(negedge clock); n++;
      if (n > 100) begin ok = 1'b0; return; end
    end
    repeat (7) @(posedge clock);
    #1 TX_READY_LD = 1'b1;
    @(negedge clock);
    obs = {SYN_GEN_LD, CRC_16, TX_LAST_BYTE, tx_data};
    @(posedge clock); #1 TX_READY_LD = 1'b0;
  endtask

  task automatic end_packet();
    @(posedge clock); #1 T_lastbit = 1'b1;
    @(posedge clock); #1 T_lastbit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(negedge clock); n++; end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1 checks++;
    if ({pl_ready, pkt_ack, pkt_done, pkt_err, busy, SYN_GEN_LD, TX_LOAD, CRC_16, TX_LAST_BYTE,
         tx_data} !== 17'h0) begin
      failures++; $display("FAIL reset_outputs: got busy=%b tx_data=%h TX_LOAD=%b want all 0",
                           busy, tx_data, TX_LOAD);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock); checks++;
    if ({busy, TX_LOAD, pl_ready, tx_data} !== 11'h0) begin
      failures++; $display("FAIL idle_after_reset: got busy=%b TX_LOAD=%b want 0", busy, TX_LOAD);
    end
  endtask

  task automatic test_handshake();
    logic [10:0] obs; bit ok; int lat;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'hD2});
    do_req(2'd0, 4'h2, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL hs_ack_latency: got %0d want 1", lat); end
    repeat (2) begin
      ser_byte(obs, ok); checks++;
      if (!ok || exp_q.size() == 0 || obs !== exp_q[0]) begin
        failures++; $display("FAIL hs_byte: got %h want %h ok=%0d", obs,
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0, ok);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clock); checks++;
    if ({TX_LOAD, TX_LAST_BYTE, busy} !== 3'b011) begin
      failures++; $display("FAIL hs_wait_end: got %b want 011", {TX_LOAD, TX_LAST_BYTE, busy});
    end
    end_packet();
    @(negedge clock); checks++;
    if (pkt_done !== 1'b1) begin failures++; $display("FAIL hs_done: got %b want 1", pkt_done); end
    repeat (7) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hs_gap_busy: got %b want 1", busy); end
    @(negedge clock); checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL hs_gap_end: got %b want 0", busy); end
  endtask

  task automatic test_data();
    logic [10:0] obs; bit ok; int lat;
    src_q.push_back({1'b0, 8'h11}); src_q.push_back({1'b0, 8'h44}); src_q.push_back({1'b1, 8'hAA});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'hC3});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h44});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'hAA});
    do_req(2'd2, 4'h3, lat);
    repeat (5) begin
      ser_byte(obs, ok); checks++;
      if (!ok || exp_q.size() == 0 || obs !== exp_q[0]) begin
        failures++; $display("FAIL data_byte: got %h want %h ok=%0d", obs,
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0, ok);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    end_packet();
    @(negedge clock); checks++;
    if (pkt_done !== 1'b1) begin failures++; $display("FAIL data_done: got %b want 1", pkt_done); end
  endtask

  // Request raised one clock after pkt_done must wait out the gap; then a token packet.
  task automatic test_ipg_token();
    logic [10:0] obs; bit ok; int lat;
    src_q.push_back({1'b0, 8'h5A}); src_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'hE1});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h5A});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'hA5});
    do_req(2'd1, 4'h1, lat);
    checks++;
    if (lat < 0 || ack_cyc - done_cyc < Ipg) begin
      failures++; $display("FAIL ipg_ack: got %0d clocks after done want >= %0d",
                           ack_cyc - done_cyc, Ipg);
    end
    repeat (4) begin
      ser_byte(obs, ok); checks++;
      if (!ok || exp_q.size() == 0 || obs !== exp_q[0]) begin
        failures++; $display("FAIL token_byte: got %h want %h ok=%0d", obs,
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0, ok);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    end_packet();
    wait_idle();
  endtask

  task automatic test_underrun();
    logic [10:0] obs; bit ok; int lat; int errs;
    src_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'hC3});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h11});
    do_req(2'd2, 4'h3, lat);
    repeat (3) begin
      ser_byte(obs, ok); checks++;
      if (!ok || exp_q.size() == 0 || obs !== exp_q[0]) begin
        failures++; $display("FAIL underrun_byte: got %h want %h ok=%0d", obs,
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0, ok);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    errs = n_err;
    ser_byte(obs, ok);
    @(negedge clock); checks++;
    if (pkt_err !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL underrun_err: got err=%b busy=%b want 1 1", pkt_err, busy);
    end
    repeat (7) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || n_err != errs + 1) begin
      failures++; $display("FAIL underrun_gap: got busy=%b errs=%0d want 1 %0d", busy,
                           n_err - errs, 1);
    end
    @(negedge clock); checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL underrun_idle: got %b want 0", busy); end
  endtask

  task automatic test_token_short();
    logic [10:0] obs; bit ok; int lat;
    src_q.push_back({1'b1, 8'h5A});
    do_req(2'd1, 4'h1, lat);
    repeat (3) ser_byte(obs, ok);
    @(negedge clock); checks++;
    if (pkt_err !== 1'b1) begin
      failures++; $display("FAIL token_short_err: got %b want 1", pkt_err);
    end
    wait_idle();
  endtask

  task automatic test_reserved();
    int lat; int acks;
    acks = n_ack;
    do_req(2'd3, 4'h5, lat);
    checks++;
    if (lat !== 1 || n_ack != acks || busy !== 1'b0) begin
      failures++; $display("FAIL reserved: got lat=%0d acks=%0d busy=%b want 1 0 0", lat,
                           n_ack - acks, busy);
    end
  endtask

  // TX_READY_LD held high: every payload byte must be refilled without a bubble.
  task automatic test_back_to_back();
    int lat; int errs; int n = 0;
    errs = n_err;
    src_q.push_back({1'b0, 8'h01}); src_q.push_back({1'b0, 8'h02});
    src_q.push_back({1'b0, 8'h03}); src_q.push_back({1'b1, 8'h04});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h0F});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h01});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h02});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h03});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h04});
    do_req(2'd2, 4'hF, lat);
    #1 TX_READY_LD = 1'b1;
    repeat (6) begin
      @(negedge clock); checks++;
      if (exp_q.size() == 0 || {SYN_GEN_LD, CRC_16, TX_LAST_BYTE, tx_data} !== exp_q[0]) begin
        failures++; $display("FAIL b2b_byte: got %h want %h",
                             {SYN_GEN_LD, CRC_16, TX_LAST_BYTE, tx_data},
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clock); #1 TX_READY_LD = 1'b0;
    checks++;
    if (n_err != errs || TX_LOAD !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_end: got errs=%0d TX_LOAD=%b want 0 0", n_err - errs, TX_LOAD);
    end
    end_packet();
    while (n < 20 && !pkt_done) begin @(negedge clock); n++; end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs; bit ok; int lat;
    src_q.push_back({1'b0, 8'h11}); src_q.push_back({1'b0, 8'h22}); src_q.push_back({1'b1, 8'h33});
    do_req(2'd2, 4'h3, lat);
    repeat (2) ser_byte(obs, ok);
    @(negedge clock); checks++;
    if ({TX_LOAD, CRC_16, busy} !== 3'b111) begin
      failures++; $display("FAIL mid_payload: got %b want 111", {TX_LOAD, CRC_16, busy});
    end
    @(posedge clock); #3 reset = 1'b0;
    src_q.delete(); exp_q.delete();
    #1 checks++;
    if ({pl_ready, pkt_ack, pkt_done, pkt_err, busy, SYN_GEN_LD, TX_LOAD, CRC_16, TX_LAST_BYTE,
         tx_data} !== 17'h0) begin
      failures++; $display("FAIL mid_reset_outputs: got busy=%b TX_LOAD=%b tx_data=%h want 0",
                           busy, TX_LOAD, tx_data);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h80});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'h5A});
    do_req(2'd0, 4'hA, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL post_reset_ack: got %0d want 1", lat); end
    repeat (2) begin
      ser_byte(obs, ok); checks++;
      if (!ok || exp_q.size() == 0 || obs !== exp_q[0]) begin
        failures++; $display("FAIL post_reset_byte: got %h want %h ok=%0d", obs,
                             (exp_q.size() > 0) ? exp_q[0] : 11'h0, ok);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_wait_end_limit();
    int errs;
    errs = n_err;
`ifdef USB_TXC_WDOG_EN
    repeat (Wdog) @(negedge clock);
    checks++;
    if (n_err != errs || pkt_err !== 1'b0) begin
      failures++; $display("FAIL wdog_early: got errs=%0d want 0", n_err - errs);
    end
    @(negedge clock); checks++;
    if (pkt_err !== 1'b1) begin failures++; $display("FAIL wdog_err: got %b want 1", pkt_err); end
`else
    repeat (300) @(negedge clock);
    checks++;
    if (n_err != errs || busy !== 1'b1 || TX_LAST_BYTE !== 1'b1) begin
      failures++; $display("FAIL wait_end_hold: got errs=%0d busy=%b want 0 1", n_err - errs, busy);
    end
    end_packet();
    @(negedge clock); checks++;
    if (pkt_done !== 1'b1) begin failures++; $display("FAIL late_done: got %b want 1", pkt_done); end
`endif
    wait_idle();
  endtask

  task automatic test_pulses();
    checks++;
    if (viol != 0 || exp_q.size() != 0) begin
      failures++; $display("FAIL pulse_rules: got viol=%0d leftover=%0d want 0 0", viol,
                           exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_data();
    test_ipg_token();
    test_underrun();
    test_token_short();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    test_wait_end_limit();
    test_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/usb_tx_pkt_ctrl.md
USB_TX_PKT_CTRL -- requirements
Module: usb_tx_pkt_ctrl

Interface
REQ-001 Parameter IPG_CYCLES, default 8: minimum idle clocks from pkt_done to the next pkt_ack.
REQ-002 Parameter WDOG_CYCLES, default 256: maximum clocks spent in WAIT_END (used only when USB_TXC_WDOG_EN is defined).
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pkt_req  in  1  requester asks to send a packet; held until pkt_ack.
REQ-006 pkt_type  in  2  0 = handshake (PID only), 1 = token (PID + 2 bytes, CRC5), 2 = data (PID + N bytes, CRC16), 3 = reserved.
REQ-007 pkt_pid  in  4  PID value; sampled with pkt_req.
REQ-008 pl_valid/pl_data/pl_last  in  1/8/1  payload byte stream; pl_last marks the final payload byte.
REQ-009 pl_ready  out  1  payload byte accepted when pl_valid && pl_ready.
REQ-010 pkt_ack/pkt_done/pkt_err/busy  out  1 each  request accepted pulse / packet fully serialized pulse / abort pulse / controller not IDLE.
REQ-011 SYN_GEN_LD/TX_LOAD/CRC_16/TX_LAST_BYTE  out  1 each  control to tx serializer.
REQ-012 tx_data  out  8  byte presented to tx serializer.
REQ-013 TX_READY_LD/T_lastbit  in  1 each  serializer consumed tx_data this cycle / last bit (incl. CRC) shifted out.

Function
REQ-014 States SHALL be IDLE, SYNC, PID, PAYLOAD, WAIT_END, GAP.
REQ-015 IDLE: pkt_req=1 with type!=3 SHALL pulse pkt_ack the next cycle, latch type/pid, enter SYNC; type 3 SHALL pulse pkt_err only.
REQ-016 SYNC: TX_LOAD=1, SYN_GEN_LD=1, tx_data=8'h80; on TX_READY_LD, enter PID.
REQ-017 PID: SYN_GEN_LD=0, tx_data={~pid,pid}, CRC_16=(type==2); handshake SHALL also assert TX_LAST_BYTE; on TX_READY_LD, handshake goes to WAIT_END, others to PAYLOAD.
REQ-018 A one-byte holding register SHALL prefetch payload; pl_ready=1 only while it is empty and state is PID or PAYLOAD.
REQ-019 PAYLOAD: tx_data=holding byte, TX_LAST_BYTE=held pl_last flag; on TX_READY_LD the byte is consumed; with pl_last, go to WAIT_END.
REQ-020 Byte consumed and new pl_valid in the same cycle SHALL refill the register without a bubble.
REQ-021 Underrun (TX_READY_LD in PAYLOAD with holding empty): pulse pkt_err, drop TX_LOAD, enter GAP.
REQ-022 Token with pl_last on byte 1 or missing on byte 2 SHALL be an underrun/error (pkt_err), i.e. exactly 2 bytes.
REQ-023 WAIT_END: TX_LOAD=0, TX_LAST_BYTE held; on T_lastbit pulse pkt_done, enter GAP.
REQ-024 GAP: counter counts IPG_CYCLES clocks, then IDLE; pkt_req is ignored during GAP.
REQ-025 busy=1 in every state except IDLE; pkt_ack, pkt_done and pkt_err SHALL be single-cycle pulses, mutually exclusive.

Reset
REQ-026 reset=0 SHALL immediately force IDLE and clear the holding register and counters.
REQ-027 During reset all outputs SHALL be 0 (tx_data=8'h00); no GAP is enforced after reset release.

Configuration
REQ-028 USB_TXC_WDOG_EN defined: WAIT_END exceeding WDOG_CYCLES without T_lastbit pulses pkt_err and enters GAP.
REQ-029 USB_TXC_WDOG_EN undefined: WAIT_END waits indefinitely and no watchdog logic is present.

Verification
REQ-030 Handshake pid=4'h2, TX_READY_LD every 8 clk -> tx_data 80,D2; TX_LAST_BYTE with D2; pkt_done after T_lastbit.
REQ-031 Data pid=4'h3, payload 11,44,AA (last) -> tx_data 80,C3,11,44,AA; CRC_16=1; TX_LAST_BYTE only with AA.
REQ-032 Data packet, pl_valid held low after first byte -> pkt_err at second TX_READY_LD; IDLE after 8 gap clocks.
REQ-033 pkt_req 1 clk after pkt_done -> pkt_ack no earlier than IPG_CYCLES clocks later.
REQ-034 reset=0 mid-PAYLOAD -> all outputs 0 same cycle; new request accepted right after release.
REQ-035 With USB_TXC_WDOG_EN defined and T_lastbit withheld -> pkt_err 256 clk after WAIT_END entry.
